// File: rtl/async_fifo_wr_arbiter_if.sv
// Write-side bus between the requesters, the arbiter and the async FIFO
// write-pointer logic.
//   req       per-requester "word available", held until acked
//   req_data  requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   full      registered FIFO full flag
//   gnt       one-hot burst owner
//   ack       one-hot, owner's word accepted this cycle
//   w_en      FIFO write enable
//   w_data    FIFO write data
//   busy      burst in progress
// The master modport is the requester/FIFO side, the slave modport the arbiter.
interface async_fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          full;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            ack;
    logic                          w_en;
    logic [DATA_WIDTH-1:0]         w_data;
    logic                          busy;

    modport master (
        output req, req_data, full,
        input  gnt, ack, w_en, w_data, busy
    );

    modport slave (
        input  req, req_data, full,
        output gnt, ack, w_en, w_data, busy
    );
endinterface

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ
// write-domain requesters. The winner owns the port for a burst of up to
// MAX_BURST words; its data is muxed onto w_data and w_en is gated by the
// FIFO's registered full flag. Entirely in the wclk domain.
// Ports:
//   wclk    write-domain clock
//   wrst_n  asynchronous active-low reset
//   bus     slave side of async_fifo_wr_arbiter_if (req/req_data/full in,
//           gnt/ack/w_en/w_data/busy out)
//
// state | meaning
// IDLE  | no owner; arbitrate among set req, no write this cycle
// BURST | owner holds gnt; writes whenever its req is set and FIFO not full
module async_fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    async_fifo_wr_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t               state_q, state_d;
    // owner_q doubles as last_owner: it keeps the previous winner through IDLE
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]     pick;
    logic                 found;
    int                   scan_idx;
    logic                 w_en;
    logic [NUM_REQ-1:0]   ack;
    logic [DATA_WIDTH-1:0] w_data;

    // Scan starts just after the last owner so it gets lowest priority.
    always_comb begin
        pick     = owner_q;
        found    = 1'b0;
        scan_idx = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = (int'(owner_q) + k) % NUM_REQ;
            if (!found && bus.req[scan_idx]) begin
                pick  = IDX_W'(scan_idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        w_en    = 1'b0;
        ack     = '0;
        w_data  = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BURST;
                    owner_d = pick;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                w_data = bus.req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
                if (bus.req[owner_q] && !bus.full) begin
                    w_en         = 1'b1;
                    ack[owner_q] = 1'b1;
                    cnt_d        = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                    end
                end else if (!bus.req[owner_q]) begin
                    // dropping req forfeits the rest of the burst
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d = '0;
        if (state_d == BURST) begin
            gnt_d[owner_d] = 1'b1;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q <= IDLE;
            owner_q <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.ack    = ack;
    assign bus.w_en   = w_en;
    assign bus.w_data = w_data;
    assign bus.busy   = (state_q == BURST);
endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
module tb_async_fifo_wr_arbiter;
    logic wclk = 1'b0;
    logic wrst_n = 1'b0;
    int   cmp = 0;
    int   fails = 0;

    always #5 wclk = ~wclk;

    async_fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus_a();
    async_fifo_wr_arbiter_if #(.NUM_REQ(2), .DATA_WIDTH(8)) bus_b();

    async_fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut_a (
        .wclk(wclk), .wrst_n(wrst_n), .bus(bus_a));
    async_fifo_wr_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .MAX_BURST(1)) dut_b (
        .wclk(wclk), .wrst_n(wrst_n), .bus(bus_b));

    // Reference model for dut_a: current owner (-1 = none), previous winner,
    // words written in the current burst.
    int m_owner, m_last, m_words;
    logic [3:0] exp_gnt, exp_ack;
    logic       exp_wen, exp_busy;
    logic [7:0] exp_wdata;
    logic [17:0] got_v, exp_v;

    function automatic int next_owner(input int last, input logic [3:0] r);
        for (int k = 1; k <= 4; k++)
            if (r[(last + k) % 4]) return (last + k) % 4;
        return last;
    endfunction

    always @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            m_owner <= -1;
            m_last  <= 3;
            m_words <= 0;
        end else if (m_owner < 0) begin
            if (bus_a.req != 4'b0) begin
                m_owner <= next_owner(m_last, bus_a.req);
                m_last  <= next_owner(m_last, bus_a.req);
                m_words <= 0;
            end
        end else if (bus_a.req[m_owner] && !bus_a.full) begin
            if (m_words + 1 == 4) m_owner <= -1;
            m_words <= m_words + 1;
        end else if (!bus_a.req[m_owner]) begin
            m_owner <= -1;
        end
    end

    always_comb begin
        exp_gnt   = '0;
        exp_wen   = 1'b0;
        exp_wdata = '0;
        exp_busy  = 1'b0;
        if (m_owner >= 0) begin
            exp_busy         = 1'b1;
            exp_gnt[m_owner] = 1'b1;
            exp_wen          = bus_a.req[m_owner] & ~bus_a.full;
            exp_wdata        = bus_a.req_data[m_owner*8 +: 8];
        end
        exp_ack = exp_wen ? exp_gnt : 4'b0;
        exp_v   = {exp_gnt, exp_ack, exp_wen, exp_wdata, exp_busy};
        got_v   = {bus_a.gnt, bus_a.ack, bus_a.w_en, bus_a.w_data, bus_a.busy};
    end

    task automatic step_a();
        @(negedge wclk);
        bus_a.req_data = $urandom;
    endtask

    task automatic go_idle();
        repeat (3) begin
            step_a();
            bus_a.req  = '0;
            bus_a.full = 1'b0;
        end
    endtask

    task automatic test_reset();
        wrst_n = 1'b0;
        bus_a.req = 4'b1111; bus_a.full = 1'b0; bus_a.req_data = $urandom;
        bus_b.req = 2'b11;   bus_b.full = 1'b0; bus_b.req_data = 16'hA5C3;
        repeat (2) @(negedge wclk);
        #1;
        cmp++;
        if (got_v !== 18'h0) begin
            fails++; $display("FAIL reset_a got=%h exp=0", got_v);
        end
        cmp++;
        if ({bus_b.gnt, bus_b.ack, bus_b.w_en, bus_b.w_data, bus_b.busy} !== 14'h0) begin
            fails++; $display("FAIL reset_b got gnt=%b w_en=%b busy=%b exp 0", bus_b.gnt, bus_b.w_en, bus_b.busy);
        end
        @(negedge wclk);
        wrst_n = 1'b1;
        bus_a.req = '0;
        bus_b.req = '0;
        #1;
        cmp++;
        if (got_v !== exp_v) begin
            fails++; $display("FAIL reset_release got=%h exp=%h", got_v, exp_v);
        end
    endtask

    task automatic test_single_req();
        int nw = 0, cur = 0, bubbles = 0;
        int lens[$];
        logic [3:0] prev = '0;
        for (int cyc = 0; cyc < 40 && lens.size() < 3; cyc++) begin
            step_a();
            bus_a.req  = (nw < 10) ? 4'b0100 : 4'b0000;
            bus_a.full = 1'b0;
            #1;
            cmp++;
            if (got_v !== exp_v) begin
                fails++; $display("FAIL single_model t=%0t got=%h exp=%h", $time, got_v, exp_v);
            end
            if (bus_a.gnt == 4'b0 && nw > 0 && nw < 10) bubbles++;
            if (bus_a.w_en) begin
                nw++; cur++;
                cmp++;
                if (bus_a.gnt !== 4'b0100 || bus_a.w_data !== bus_a.req_data[23:16]) begin
                    fails++; $display("FAIL single_word gnt=%b data=%h exp gnt=0100 data=%h", bus_a.gnt, bus_a.w_data, bus_a.req_data[23:16]);
                end
            end
            if (bus_a.gnt == 4'b0 && prev != 4'b0) begin
                lens.push_back(cur); cur = 0;
            end
            prev = bus_a.gnt;
        end
        cmp++;
        if (lens.size() != 3 || nw != 10) begin
            fails++; $display("FAIL single_count bursts=%0d words=%0d exp 3/10", lens.size(), nw);
        end else if (lens[0] != 4 || lens[1] != 4 || lens[2] != 2) begin
            fails++; $display("FAIL single_lens got %0d,%0d,%0d exp 4,4,2", lens[0], lens[1], lens[2]);
        end
        cmp++;
        if (bubbles != 2) begin
            fails++; $display("FAIL single_bubbles got=%0d exp=2", bubbles);
        end
    endtask

    task automatic test_all_req();
        int owners[$];
        int lens[$];
        int cur = 0;
        logic [3:0] prev = '0;
        step_a(); wrst_n = 1'b0; bus_a.req = '0; bus_a.full = 1'b0;
        step_a(); wrst_n = 1'b1;
        for (int cyc = 0; cyc < 40 && lens.size() < 5; cyc++) begin
            if (cyc > 0) step_a();
            bus_a.req = 4'b1111;
            #1;
            cmp++;
            if (got_v !== exp_v) begin
                fails++; $display("FAIL all_model t=%0t got=%h exp=%h", $time, got_v, exp_v);
            end
            if (bus_a.gnt != 4'b0 && prev == 4'b0)
                for (int i = 0; i < 4; i++) if (bus_a.gnt[i]) owners.push_back(i);
            if (bus_a.w_en) cur++;
            if (bus_a.gnt == 4'b0 && prev != 4'b0) begin
                lens.push_back(cur); cur = 0;
            end
            prev = bus_a.gnt;
        end
        cmp++;
        if (owners.size() < 5 || lens.size() != 5) begin
            fails++; $display("FAIL all_bursts got owners=%0d bursts=%0d exp 5", owners.size(), lens.size());
        end else begin
            for (int b = 0; b < 5; b++) begin
                cmp++;
                if (owners[b] != b % 4 || lens[b] != 4) begin
                    fails++; $display("FAIL all_burst%0d owner=%0d len=%0d exp owner=%0d len=4", b, owners[b], lens[b], b % 4);
                end
            end
        end
    endtask

    task automatic test_full_stall();
        int nw = 0, stall = 0, stalled_obs = 0, grants = 0;
        logic [3:0] prev = '0;
        go_idle();
        for (int cyc = 0; cyc < 30; cyc++) begin
            step_a();
            bus_a.req  = (nw < 4) ? 4'b0010 : 4'b0000;
            bus_a.full = (nw == 2 && stall < 3);
            if (bus_a.full) stall++;
            #1;
            cmp++;
            if (got_v !== exp_v) begin
                fails++; $display("FAIL stall_model t=%0t got=%h exp=%h", $time, got_v, exp_v);
            end
            if (bus_a.full && bus_a.w_en) begin
                cmp++; fails++; $display("FAIL stall_wen got w_en=1 exp 0 while full");
            end
            if (bus_a.gnt != 4'b0 && !bus_a.w_en) stalled_obs++;
            if (bus_a.gnt != 4'b0 && prev == 4'b0) grants++;
            if (bus_a.w_en) nw++;
            prev = bus_a.gnt;
        end
        cmp++;
        if (nw != 4 || stalled_obs != 3 || grants != 1) begin
            fails++; $display("FAIL stall_summary writes=%0d stalls=%0d grants=%0d exp 4/3/1", nw, stalled_obs, grants);
        end
    endtask

    task automatic test_req_drop();
        int nw = 0;
        go_idle();
        for (int cyc = 0; cyc < 10 && nw < 2; cyc++) begin
            step_a();
            bus_a.req = 4'b0001;
            #1;
            cmp++;
            if (got_v !== exp_v) begin
                fails++; $display("FAIL drop_model t=%0t got=%h exp=%h", $time, got_v, exp_v);
            end
            if (bus_a.w_en) nw++;
        end
        step_a();
        bus_a.req = 4'b0000;
        #1;
        cmp++;
        if (bus_a.w_en !== 1'b0 || got_v !== exp_v) begin
            fails++; $display("FAIL drop_forfeit got=%h exp=%h", got_v, exp_v);
        end
        step_a();
        bus_a.req = 4'b1111;
        #1;
        cmp++;
        if (bus_a.gnt !== 4'b0 || bus_a.busy !== 1'b0) begin
            fails++; $display("FAIL drop_idle gnt=%b busy=%b exp 0000/0", bus_a.gnt, bus_a.busy);
        end
        step_a();
        #1;
        cmp++;
        if (bus_a.gnt !== 4'b0010) begin
            fails++; $display("FAIL drop_next_owner gnt=%b exp 0010", bus_a.gnt);
        end
    endtask

    task automatic test_reset_mid_burst();
        int nw = 0;
        go_idle();
        for (int cyc = 0; cyc < 10 && nw < 2; cyc++) begin
            step_a();
            bus_a.req = 4'b1000;
            #1;
            cmp++;
            if (got_v !== exp_v) begin
                fails++; $display("FAIL rstmid_model t=%0t got=%h exp=%h", $time, got_v, exp_v);
            end
            if (bus_a.w_en) nw++;
        end
        step_a();
        wrst_n = 1'b0;
        #1;
        cmp++;
        if (got_v !== 18'h0) begin
            fails++; $display("FAIL rstmid_clear got=%h exp=0", got_v);
        end
        step_a();
        wrst_n = 1'b1;
        bus_a.req = 4'b1111;
        #1;
        cmp++;
        if (bus_a.gnt !== 4'b0) begin
            fails++; $display("FAIL rstmid_idle gnt=%b exp 0000", bus_a.gnt);
        end
        step_a();
        #1;
        cmp++;
        if (bus_a.gnt !== 4'b0001 || bus_a.w_en !== 1'b1) begin
            fails++; $display("FAIL rstmid_first gnt=%b w_en=%b exp 0001/1", bus_a.gnt, bus_a.w_en);
        end
    endtask

    task automatic test_random();
        logic [3:0] ackp = '0;
        logic [3:0] r;
        for (int cyc = 0; cyc < 400; cyc++) begin
            step_a();
            for (int i = 0; i < 4; i++) begin
                if (bus_a.req[i] && !ackp[i] && $urandom_range(0, 9) != 0) r[i] = 1'b1;
                else r[i] = 1'($urandom_range(0, 1));
            end
            bus_a.req  = r;
            bus_a.full = ($urandom_range(0, 3) == 0);
            #1;
            cmp++;
            if (got_v !== exp_v) begin
                fails++; $display("FAIL random_model t=%0t got=%h exp=%h", $time, got_v, exp_v);
            end
            if ($countones(bus_a.ack) > 1 || (bus_a.w_en && bus_a.full)) begin
                cmp++; fails++; $display("FAIL random_invariant ack=%b w_en=%b full=%b", bus_a.ack, bus_a.w_en, bus_a.full);
            end
            ackp = bus_a.ack;
        end
        bus_a.req = '0;
    endtask

    task automatic test_max_burst1();
        logic [1:0] eg;
        @(negedge wclk);
        bus_b.req = 2'b11; bus_b.full = 1'b0; bus_b.req_data = $urandom;
        #1;
        cmp++;
        if (bus_b.gnt !== 2'b00) begin
            fails++; $display("FAIL mb1_idle gnt=%b exp 00", bus_b.gnt);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge wclk);
            bus_b.req_data = $urandom;
            #1;
            eg = (k % 2 == 1) ? 2'b00 : ((k % 4 == 0) ? 2'b01 : 2'b10);
            cmp++;
            if (bus_b.gnt !== eg || bus_b.w_en !== (eg != 2'b00) || bus_b.ack !== eg) begin
                fails++; $display("FAIL mb1_cycle%0d gnt=%b ack=%b w_en=%b exp gnt=ack=%b", k, bus_b.gnt, bus_b.ack, bus_b.w_en, eg);
            end
            if (eg != 2'b00) begin
                cmp++;
                if (bus_b.w_data !== (eg == 2'b01 ? bus_b.req_data[7:0] : bus_b.req_data[15:8])) begin
                    fails++; $display("FAIL mb1_data%0d got=%h", k, bus_b.w_data);
                end
            end
        end
        bus_b.req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_req();
        test_all_req();
        test_full_stall();
        test_req_drop();
        test_reset_mid_burst();
        test_random();
        test_max_burst1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
        $finish;
    end
endmodule
